// File: rtl/rv32_fetch_unit.sv
// rv32 instruction fetch stage.
// Keeps the fetch PC, issues single-word reads to instruction memory and hands
// each returned word to decode through a valid/ready handshake. A redirect from
// execute replaces the fetch PC in any state. Any read already in flight when the
// redirect arrives is marked stale, and its data is dropped when it returns.
// Every output comes straight from a register.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        memory_read_request,
    output logic [31:0] memory_read_address,
    input  logic        memory_read_valid,
    input  logic [31:0] memory_read_value,
    output logic [31:0] pc,
    output logic [31:0] pc_instruction,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic        fetch_misaligned
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_WAIT    = 2'd2,
        ST_HOLD    = 2'd3
    } fetch_state_t;

    fetch_state_t state_r;
    fetch_state_t state_nxt_s;

    logic [31:0] fetch_pc_r;
    logic [31:0] fetch_pc_seq_s;
    logic [31:0] fetch_pc_nxt_s;
    logic        squash_r;
    logic        squash_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] pc_instruction_r;
    logic [31:0] pc_instruction_nxt_s;
    logic        instruction_valid_r;
    logic        instruction_valid_nxt_s;
    logic        memory_read_request_r;
    logic        memory_read_request_nxt_s;
    logic [31:0] memory_read_address_r;
    logic [31:0] memory_read_address_nxt_s;
    logic        fetch_misaligned_r;

    logic [31:0] redirect_aligned_s;
    logic        redirect_misaligned_s;

    // The low two bits of a redirect target are dropped. If either was set, a misaligned pulse is raised.
    assign redirect_aligned_s    = {redirect_pc[31:2], 2'b00};
    assign redirect_misaligned_s = |redirect_pc[1:0];

    // Next-state and next-output logic. A redirect overrides the sequential fetch PC in every state.
    always_comb begin
        state_nxt_s               = state_r;
        fetch_pc_seq_s            = fetch_pc_r;
        fetch_pc_nxt_s            = fetch_pc_r;
        squash_nxt_s              = squash_r;
        pc_nxt_s                  = pc_r;
        pc_instruction_nxt_s      = pc_instruction_r;
        instruction_valid_nxt_s   = instruction_valid_r;
        memory_read_request_nxt_s = 1'b0;
        memory_read_address_nxt_s = memory_read_address_r;

        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_REQUEST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                // The strobe for the old address is already on the bus; a redirect only marks it stale.
                state_nxt_s = ST_WAIT;
                if (redirect_valid) begin
                    squash_nxt_s = 1'b1;
                end else begin
                    squash_nxt_s = squash_r;
                end
            end
            ST_WAIT: begin
                if (memory_read_valid) begin
                    if (squash_r || redirect_valid) begin
                        // Stale data: drop it and refetch from the (possibly new) fetch PC.
                        squash_nxt_s = 1'b0;
                        state_nxt_s  = ST_REQUEST;
                    end else begin
                        pc_nxt_s                = fetch_pc_r;
                        pc_instruction_nxt_s    = memory_read_value;
                        instruction_valid_nxt_s = 1'b1;
                        state_nxt_s             = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    squash_nxt_s = 1'b1;
                    state_nxt_s  = ST_WAIT;
                end else begin
                    squash_nxt_s = squash_r;
                    state_nxt_s  = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    instruction_valid_nxt_s = 1'b0;
                    pc_instruction_nxt_s    = NOP_WORD;
                    state_nxt_s             = ST_REQUEST;
                end else if (instruction_ready) begin
                    instruction_valid_nxt_s = 1'b0;
                    fetch_pc_seq_s          = fetch_pc_r + 32'd4;
                    if (enable) begin
                        state_nxt_s = ST_REQUEST;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (redirect_valid) begin
            fetch_pc_nxt_s = redirect_aligned_s;
        end else begin
            fetch_pc_nxt_s = fetch_pc_seq_s;
        end

        // The strobe and address are registered on the way into REQUEST, so they are visible for that one cycle.
        if (state_nxt_s == ST_REQUEST) begin
            memory_read_request_nxt_s = 1'b1;
            memory_read_address_nxt_s = fetch_pc_nxt_s;
        end else begin
            memory_read_request_nxt_s = 1'b0;
            memory_read_address_nxt_s = memory_read_address_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fetch PC, squash flag and the registered outputs toward memory and decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r            <= RESET_VECTOR;
            squash_r              <= 1'b0;
            pc_r                  <= RESET_VECTOR;
            pc_instruction_r      <= NOP_WORD;
            instruction_valid_r   <= 1'b0;
            memory_read_request_r <= 1'b0;
            memory_read_address_r <= RESET_VECTOR;
            fetch_misaligned_r    <= 1'b0;
        end else begin
            fetch_pc_r            <= fetch_pc_nxt_s;
            squash_r              <= squash_nxt_s;
            pc_r                  <= pc_nxt_s;
            pc_instruction_r      <= pc_instruction_nxt_s;
            instruction_valid_r   <= instruction_valid_nxt_s;
            memory_read_request_r <= memory_read_request_nxt_s;
            memory_read_address_r <= memory_read_address_nxt_s;
            fetch_misaligned_r    <= redirect_valid & redirect_misaligned_s;
        end
    end

    assign memory_read_request = memory_read_request_r;
    assign memory_read_address = memory_read_address_r;
    assign pc                  = pc_r;
    assign pc_instruction      = pc_instruction_r;
    assign instruction_valid   = instruction_valid_r;
    assign fetch_misaligned    = fetch_misaligned_r;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Self-checking bench for rv32_fetch_unit.
// A behavioural instruction memory answers each read strobe after a configurable
// latency. The returned word is a fixed function of the address.
// The expected request addresses and decode PCs are queued when stimulus is driven.
// They are popped and compared when the DUT issues a request or decode consumes an instruction.
module tb_rv32_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        memory_read_request;
    logic [31:0] memory_read_address;
    logic        memory_read_valid = 1'b0;
    logic [31:0] memory_read_value = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_instruction;
    logic        instruction_valid;
    logic        instruction_ready = 1'b0;
    logic        fetch_misaligned;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int mis_cnt = 0;
    int last_consume = -1;
    bit tput_en = 1'b0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] mon_exp;

    int          mem_latency = 1;
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = 32'h0;
    bit          mem_bad_en = 1'b0;
    logic [31:0] mem_bad_addr = 32'h0;

    rv32_fetch_unit dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .enable              (enable),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .memory_read_request (memory_read_request),
        .memory_read_address (memory_read_address),
        .memory_read_valid   (memory_read_valid),
        .memory_read_value   (memory_read_value),
        .pc                  (pc),
        .pc_instruction      (pc_instruction),
        .instruction_valid   (instruction_valid),
        .instruction_ready   (instruction_ready),
        .fetch_misaligned    (fetch_misaligned)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    // Instruction memory model: it returns the word mem_latency cycles after it sees the strobe.
    always @(negedge clock) begin
        memory_read_valid = 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                memory_read_valid = 1'b1;
                memory_read_value = mem_data;
                mem_busy = 1'b0;
            end else begin
                mem_cnt = mem_cnt - 1;
            end
        end
        if (memory_read_request) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_latency - 1;
            mem_data = (mem_bad_en && memory_read_address == mem_bad_addr) ?
                       32'hDEAD_BEEF : instr_of(memory_read_address);
        end
    end

    // Monitor: it samples between edges and checks requests and consumes against the scoreboard.
    always begin
        @(negedge clock);
        #2;
        cyc++;
        if (reset_n) begin
            if (fetch_misaligned) mis_cnt++;
            if (memory_read_request) begin
                if (exp_addr_q.size() == 0) begin
                    check_eq("req_unexpected", {31'd0, memory_read_request}, 32'd0);
                end else begin
                    mon_exp = exp_addr_q.pop_front();
                    check_eq("req_addr", memory_read_address, mon_exp);
                end
            end
            if (instruction_valid && instruction_ready) begin
                if (exp_pc_q.size() == 0) begin
                    check_eq("dec_unexpected", {31'd0, instruction_valid}, 32'd0);
                end else begin
                    mon_exp = exp_pc_q.pop_front();
                    check_eq("dec_pc", pc, mon_exp);
                    check_eq("dec_instr", pc_instruction, instr_of(mon_exp));
                end
                if (tput_en) begin
                    if (last_consume >= 0) check_eq("throughput", 32'(cyc - last_consume), 32'd3);
                    last_consume = cyc;
                end
            end
        end
    end

    task automatic check_reset_state();
        check_eq("rst_pc", pc, 32'h0000_0000);
        check_eq("rst_instr", pc_instruction, NOP);
        check_eq("rst_req", {31'd0, memory_read_request}, 32'd0);
        check_eq("rst_addr", memory_read_address, 32'h0000_0000);
        check_eq("rst_ivalid", {31'd0, instruction_valid}, 32'd0);
        check_eq("rst_misaligned", {31'd0, fetch_misaligned}, 32'd0);
    endtask

    task automatic drain_pc(input int budget);
        int n = 0;
        while (exp_pc_q.size() != 0 && n < budget) begin
            @(negedge clock);
            #3;
            n++;
        end
        check_eq("drain_pc", 32'(exp_pc_q.size()), 32'd0);
    endtask

    task automatic drain_all(input int budget);
        int n = 0;
        while ((exp_pc_q.size() != 0 || exp_addr_q.size() != 0) && n < budget) begin
            @(negedge clock);
            #3;
            n++;
        end
        check_eq("drain_all", 32'(exp_pc_q.size() + exp_addr_q.size()), 32'd0);
    endtask

    task automatic wait_ivalid(input int budget);
        int n = 0;
        while (!instruction_valid && n < budget) begin
            @(negedge clock);
            #3;
            n++;
        end
        check_eq("ivalid_wait", {31'd0, instruction_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values.
        @(negedge clock);
        #3;
        check_reset_state();

        // Sequential fetch 0,4,8,C with one-cycle memory and a ready decoder.
        @(negedge clock);
        reset_n = 1'b1;
        enable = 1'b1;
        instruction_ready = 1'b1;
        mem_latency = 1;
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_addr_q.push_back(32'hC);
        exp_addr_q.push_back(32'h10);
        exp_pc_q.push_back(32'h0);
        exp_pc_q.push_back(32'h4);
        exp_pc_q.push_back(32'h8);
        exp_pc_q.push_back(32'hC);
        last_consume = -1;
        tput_en = 1'b1;
        drain_pc(100);

        // Decode stalls: 0x10 is held stable and no new request is issued.
        @(negedge clock);
        instruction_ready = 1'b0;
        enable = 1'b0;
        tput_en = 1'b0;
        wait_ivalid(20);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_pc", pc, 32'h10);
            check_eq("hold_instr", pc_instruction, instr_of(32'h10));
            check_eq("hold_ivalid", {31'd0, instruction_valid}, 32'd1);
            check_eq("hold_req", {31'd0, memory_read_request}, 32'd0);
            @(negedge clock);
            #3;
        end
        @(negedge clock);
        exp_pc_q.push_back(32'h10);
        instruction_ready = 1'b1;
        drain_all(50);

        // Redirect while WAIT: the stale DEADBEEF for 0x14 must be dropped.
        @(negedge clock);
        mem_latency = 3;
        mem_bad_en = 1'b1;
        mem_bad_addr = 32'h14;
        exp_addr_q.push_back(32'h14);
        exp_addr_q.push_back(32'h100);
        exp_pc_q.push_back(32'h100);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clock);
        redirect_valid = 1'b0;
        drain_all(60);
        mem_bad_en = 1'b0;

        // A misaligned redirect raises one pulse, and the fetch uses the aligned address.
        @(negedge clock);
        exp_addr_q.push_back(32'h204);
        exp_pc_q.push_back(32'h204);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0206;
        enable = 1'b1;
        @(negedge clock);
        redirect_valid = 1'b0;
        enable = 1'b0;
        #3;
        check_eq("misaligned_pulse", {31'd0, fetch_misaligned}, 32'd1);
        @(negedge clock);
        #3;
        check_eq("misaligned_clear", {31'd0, fetch_misaligned}, 32'd0);
        drain_all(60);

        // Fetch PC wraps from 0xFFFF_FFFC to 0.
        @(negedge clock);
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        exp_pc_q.push_back(32'hFFFF_FFFC);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        enable = 1'b1;
        @(negedge clock);
        redirect_valid = 1'b0;
        drain_pc(60);
        @(negedge clock);
        enable = 1'b0;

        // Reset during WAIT. The late data from the old read must be ignored.
        @(negedge clock);
        reset_n = 1'b0;
        #3;
        check_reset_state();
        @(negedge clock);
        reset_n = 1'b1;
        #3;
        check_eq("post_rst_ivalid", {31'd0, instruction_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #3;
            check_eq("late_data_ivalid", {31'd0, instruction_valid}, 32'd0);
            check_eq("late_data_req", {31'd0, memory_read_request}, 32'd0);
        end
        @(negedge clock);
        exp_addr_q.push_back(32'h0000_0000);
        exp_pc_q.push_back(32'h0000_0000);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        drain_all(60);

        check_eq("misaligned_count", 32'(mis_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
